// File: rtl/dpram_line_reader_pkg.sv
// Shared widths and constants for the read side of the 2048x2-write / 256x16-read line RAM.
// Both the line sequencer and the symbol unpacker size themselves from these.
package dpram_line_reader_pkg;
    localparam int SYMS_PER_WORD = 8;
    localparam int SYM_BITS      = 2;
    localparam int RAM_WORDS     = 256;
    localparam int WORD_BITS     = SYMS_PER_WORD * SYM_BITS;
    localparam int RD_ADDR_BITS  = $clog2(RAM_WORDS);
    localparam int WR_ADDR_BITS  = $clog2(RAM_WORDS * SYMS_PER_WORD);
    localparam int SYM_CNT_BITS  = $clog2(SYMS_PER_WORD + 1);
endpackage

// File: rtl/dpram_line_reader_symbol_unpacker.sv
// Holds one 16-bit RAM word and drains it two bits at a time onto a valid/ready stream,
// lowest symbol first.
module dpram_line_reader_symbol_unpacker
    import dpram_line_reader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [WORD_BITS-1:0]    load_data,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [SYM_BITS-1:0]     out_data,
    output logic [SYM_CNT_BITS-1:0] sym_cnt
);

    logic [WORD_BITS-1:0]    sr_q, sr_d;
    logic [SYM_CNT_BITS-1:0] sym_cnt_q, sym_cnt_d;

    assign out_valid = (sym_cnt_q != '0);
    assign out_data  = sr_q[SYM_BITS-1:0];
    assign sym_cnt   = sym_cnt_q;

    // A load may coincide with the final handshake of the previous word; the load wins.
    always_comb begin
        sr_d      = sr_q;
        sym_cnt_d = sym_cnt_q;
        if (load) begin
            sr_d      = load_data;
            sym_cnt_d = SYM_CNT_BITS'(SYMS_PER_WORD);
        end else if (out_valid && out_ready) begin
            sr_d      = sr_q >> SYM_BITS;
            sym_cnt_d = sym_cnt_q - SYM_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q      <= '0;
            sym_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            sym_cnt_q <= sym_cnt_d;
        end
    end

endmodule

// File: rtl/dpram_line_reader.sv
// Read-domain line reader: walks the RAM address over one line of packed words and
// streams the unpacked 2-bit symbols downstream.
module dpram_line_reader
    import dpram_line_reader_pkg::*;
#(
    parameter int ADDR_BITS  = RD_ADDR_BITS,
    parameter int COUNT_BITS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_BITS-1:0]  base_addr,
    input  logic [COUNT_BITS-1:0] word_count,
    output logic                  busy,
    output logic [ADDR_BITS-1:0]  rd_addr,
    input  logic [WORD_BITS-1:0]  rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SYM_BITS-1:0]   out_data,
    output logic                  out_last
);

    logic                    busy_q, busy_d;
    logic [ADDR_BITS-1:0]    rd_addr_q, rd_addr_d;
    logic                    settle_q, settle_d;
    logic [COUNT_BITS-1:0]   words_left_q, words_left_d;
    logic                    fetch_pending_q, fetch_pending_d;

    logic [SYM_CNT_BITS-1:0] sym_cnt;
    logic                    handshake;
    logic                    accept;
    logic                    load;

    assign handshake = out_valid && out_ready;
    assign accept    = start && !busy_q && (word_count != '0);

    // The next word is only taken once its read data has had a full cycle to settle.
    assign load = fetch_pending_q && settle_q &&
                  ((sym_cnt == '0) || ((sym_cnt == SYM_CNT_BITS'(1)) && handshake));

    assign out_last = (sym_cnt == SYM_CNT_BITS'(1)) && !fetch_pending_q && (words_left_q == '0);
    assign busy     = busy_q;
    assign rd_addr  = rd_addr_q;

    dpram_line_reader_symbol_unpacker u_unpacker (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (rd_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sym_cnt   (sym_cnt)
    );

    // Any edge that moves the address clears settle; every other edge sets it.
    always_comb begin
        busy_d          = busy_q;
        rd_addr_d       = rd_addr_q;
        settle_d        = 1'b1;
        words_left_d    = words_left_q;
        fetch_pending_d = fetch_pending_q;
        if (accept) begin
            rd_addr_d       = base_addr;
            words_left_d    = word_count;
            fetch_pending_d = 1'b1;
            busy_d          = 1'b1;
            settle_d        = 1'b0;
        end else begin
            if (load) begin
                words_left_d = words_left_q - COUNT_BITS'(1);
                if (words_left_q > COUNT_BITS'(1)) begin
                    rd_addr_d = rd_addr_q + ADDR_BITS'(1);
                    settle_d  = 1'b0;
                end else begin
                    fetch_pending_d = 1'b0;
                end
            end
            if (handshake && out_last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q          <= 1'b0;
            rd_addr_q       <= '0;
            settle_q        <= 1'b0;
            words_left_q    <= '0;
            fetch_pending_q <= 1'b0;
        end else begin
            busy_q          <= busy_d;
            rd_addr_q       <= rd_addr_d;
            settle_q        <= settle_d;
            words_left_q    <= words_left_d;
            fetch_pending_q <= fetch_pending_d;
        end
    end

endmodule

// File: tb/tb_dpram_line_reader.sv
// Self-checking bench for dpram_line_reader: a synchronous RAM model feeds the reader and a
// queue-based reference model predicts the symbol stream and address walk of each line.
module tb_dpram_line_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  base_addr;
   logic [8:0]  word_count;
   logic        busy;
   logic [7:0]  rd_addr;
   logic [15:0] rd_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_data;
   logic        out_last;

   logic [15:0] mem [256];

   int checks = 0;
   int errors = 0;

   int expSyms[$];
   int expAddrs[$];
   bit modelBusy = 1'b0;
   bit addrFresh = 1'b0;
   int prevAddr = 0;
   int readyPct = 100;
   int handshakes = 0;
   int lastCount = 0;
   int cycle = 0;
   int firstValidCycle = -1;
   int lastHsCycle = 0;
   bit holdValid = 1'b0;
   int holdData = 0;
   int holdLast = 0;

   dpram_line_reader dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .busy       (busy),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM: data for an address appears one edge after it is presented.
   always @(posedge clk) begin
      rd_data <= mem[rd_addr];
      cycle   <= cycle + 1;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drives out_ready, consumes accepted symbols against the model and checks hold/address behaviour.
   always @(negedge clk) begin
      if (!reset) begin
         if (busy && (addrFresh || int'(rd_addr) != prevAddr)) begin
            if (expAddrs.size() == 0) checkOutput("addr_extra", int'(rd_addr), -1);
            else checkOutput("rd_addr", int'(rd_addr), expAddrs.pop_front());
            prevAddr  = int'(rd_addr);
            addrFresh = 1'b0;
         end
         if (holdValid) begin
            checkOutput("hold_valid", int'(out_valid), 1);
            checkOutput("hold_data", int'(out_data), holdData);
            checkOutput("hold_last", int'(out_last), holdLast);
         end
         out_ready = ($urandom_range(99) < readyPct);
         if (out_valid && firstValidCycle < 0) firstValidCycle = cycle;
         if (out_valid && out_ready) begin
            if (expSyms.size() == 0) begin
               checkOutput("sym_extra", int'(out_data), -1);
            end else begin
               checkOutput("sym", int'(out_data), expSyms.pop_front());
               checkOutput("last", int'(out_last), (expSyms.size() == 0) ? 1 : 0);
               if (expSyms.size() == 0) modelBusy = 1'b0;
            end
            handshakes++;
            lastHsCycle = cycle;
            if (out_last) lastCount++;
         end
         holdValid = out_valid && !out_ready;
         holdData  = int'(out_data);
         holdLast  = int'(out_last);
      end else begin
         holdValid = 1'b0;
      end
   end

   task automatic applyStimulus(input int base, input int count);
      @(negedge clk);
      base_addr  = 8'(base);
      word_count = 9'(count);
      start      = 1'b1;
      if (!modelBusy && count != 0) begin
         modelBusy = 1'b1;
         addrFresh = 1'b1;
         for (int w = 0; w < count; w++) begin
            int a;
            a = (base + w) % 256;
            expAddrs.push_back(a);
            for (int k = 0; k < 8; k++) expSyms.push_back((int'(mem[a]) >> (2 * k)) % 4);
         end
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitIdle(input int bound);
      int n;
      n = 0;
      while (busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (busy) checkOutput("idle_timeout", 1, 0);
      checkOutput("syms_drained", expSyms.size(), 0);
      checkOutput("addrs_drained", expAddrs.size(), 0);
   endtask

   task automatic runLine(input int base, input int count, input int pct, input int bound);
      readyPct   = pct;
      handshakes = 0;
      lastCount  = 0;
      applyStimulus(base, count);
      waitIdle(bound);
      checkOutput("line_syms", handshakes, 8 * count);
      checkOutput("line_lasts", lastCount, 1);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      base_addr  = '0;
      word_count = '0;
      out_ready  = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_rd_addr", int'(rd_addr), 0);
      checkOutput("rst_valid", int'(out_valid), 0);
      checkOutput("rst_data", int'(out_data), 0);
      checkOutput("rst_last", int'(out_last), 0);
      reset = 1'b0;
      @(negedge clk);

      // Single word with latency check: valid first seen after the second edge past start.
      mem[5]     = 16'hE4E4;
      readyPct   = 100;
      handshakes = 0;
      lastCount  = 0;
      applyStimulus(5, 1);
      checkOutput("lat_e0", int'(out_valid), 0);
      @(negedge clk);
      checkOutput("lat_e1", int'(out_valid), 0);
      @(negedge clk);
      checkOutput("lat_e2", int'(out_valid), 1);
      waitIdle(50);
      checkOutput("single_syms", handshakes, 8);
      checkOutput("single_lasts", lastCount, 1);

      // Full line with incrementing contents; must stream without bubbles.
      for (int i = 0; i < 256; i++) mem[i] = 16'(i);
      firstValidCycle = -1;
      runLine(0, 256, 100, 3000);
      checkOutput("full_no_bubble", lastHsCycle - firstValidCycle, 2047);

      // Address wrap.
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      runLine(254, 4, 100, 200);

      // Backpressure at roughly 30% ready.
      runLine(int'($urandom_range(255)), 2, 30, 500);

      // Randomised lines with random backpressure.
      for (int t = 0; t < 6; t++)
         runLine(int'($urandom_range(255)), int'($urandom_range(1, 12)), int'($urandom_range(20, 100)), 2000);

      // A zero-length request is ignored.
      applyStimulus(3, 0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("zero_busy", int'(busy), 0);
         checkOutput("zero_valid", int'(out_valid), 0);
         @(negedge clk);
      end

      // A start while busy is ignored and the line finishes unchanged.
      readyPct   = 60;
      handshakes = 0;
      lastCount  = 0;
      applyStimulus(40, 3);
      repeat (4) @(negedge clk);
      applyStimulus(100, 5);
      waitIdle(500);
      checkOutput("midstart_syms", handshakes, 24);
      checkOutput("midstart_lasts", lastCount, 1);

      // Reset mid-line abandons the line.
      readyPct   = 100;
      handshakes = 0;
      applyStimulus(20, 4);
      for (int n = 0; n < 200 && handshakes < 5; n++) @(negedge clk);
      checkOutput("pre_reset_progress", (handshakes >= 5) ? 1 : 0, 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_busy", int'(busy), 0);
      checkOutput("mid_rst_rd_addr", int'(rd_addr), 0);
      checkOutput("mid_rst_valid", int'(out_valid), 0);
      checkOutput("mid_rst_data", int'(out_data), 0);
      checkOutput("mid_rst_last", int'(out_last), 0);
      expSyms.delete();
      expAddrs.delete();
      modelBusy = 1'b0;
      addrFresh = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("post_rst_valid", int'(out_valid), 0);
      end
      mem[9] = 16'($urandom);
      runLine(9, 1, 100, 50);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dpram_line_reader.md
Name: dpram_line_reader

Overview:
- Read-domain consumer of the 2-bit-write / 16-bit-read clock-crossing block RAM (256 words x 16 bits).
- Sequences the RAM read address over one line of packed words and unpacks each word into eight 2-bit symbols.
- Emits the symbols on a valid/ready stream to the downstream pixel path, lowest-addressed symbol first.
- Runs entirely in the RAM read-clock domain.

Parameters:
- ADDR_BITS, 8, RAM word-address width (256 words)
- COUNT_BITS, 9, width of word_count (up to 256 words per line)

Ports:
- clk  in  1  read-domain clock, also drives the RAM read clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to read one line
- base_addr  in  ADDR_BITS  first word address, sampled with start
- word_count  in  COUNT_BITS  number of words to read, sampled with start; valid range 1..256
- busy  out  1  line in progress
- rd_addr  out  ADDR_BITS  registered RAM read address
- rd_data  in  16  RAM read data; word N holds symbol k in bits [2k+1:2k]
- out_valid  out  1  symbol available
- out_ready  in  1  downstream accepts the symbol
- out_data  out  2  current symbol
- out_last  out  1  current symbol is the final symbol of the line

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: busy=0, rd_addr=0, out_valid=0, out_data=0, out_last=0. All internal state cleared: settle, sr, sym_cnt, words_left, fetch_pending.
- Reset mid-line abandons the line; no further symbols are emitted.
- Start acceptance: start is accepted only when busy=0 and word_count!=0.
  - On acceptance: rd_addr<=base_addr, words_left<=word_count, fetch_pending<=1, busy<=1.
  - start while busy is ignored.
  - start with word_count=0 is ignored; busy stays 0.
- Settle flag:
  - Cleared on every edge that changes rd_addr; set on the following edge.
  - rd_data is valid for the current rd_addr only while settle=1.
  - rd_addr is held stable until its word is loaded.
- Load condition: fetch_pending and settle=1 and (sym_cnt==0, or sym_cnt==1 with a handshake this cycle).
- On load:
  - sr<=rd_data, sym_cnt<=8, words_left decrements.
  - If words_left>1 before the decrement: rd_addr<=rd_addr+1, wrapping 255->0, and settle<=0.
  - Otherwise fetch_pending<=0.
- Output stream:
  - out_data=sr[1:0]; out_valid=(sym_cnt!=0).
  - Handshake (out_valid and out_ready): sr shifts right by 2, sym_cnt decrements.
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
- out_last = (sym_cnt==1) and not fetch_pending and words_left==0.
- busy falls on the edge completing the out_last handshake. A new start is accepted from the next cycle.
- Latency: start sampled at edge E0 gives first out_valid after edge E2.
- Throughput: with out_ready held high, one symbol per cycle with no gaps across word boundaries, because the next word settles within the 8-symbol drain.
- Backpressure: any out_ready pattern is tolerated. No symbol is dropped or duplicated, and the RAM address is never advanced before its word is loaded.

Decomposition:
- Shared package holds:
  - SYMS_PER_WORD=8
  - SYM_BITS=2
  - RAM_WORDS=256
  - widths matching the RAM (2048x2 write / 256x16 read)
- Sub-module symbol_unpacker: 16-bit shift register plus sym_cnt, with load/shift and valid/ready logic.
- Top level owns address sequencing, settle, words_left and busy.

Test Plan:
- Single word: RAM word 5 = 0xE4E4, start with base=5, count=1, ready=1 -> out_valid first high 2 cycles after start. Symbols 0,1,2,3,0,1,2,3; out_last only on the 8th; busy low next cycle.
- Full line: base=0, count=256, incrementing contents, ready=1 -> 2048 consecutive symbols with no bubble after the first. rd_addr visits 0..255; exactly one out_last.
- Wrap: base=254, count=4 -> rd_addr sequence 254,255,0,1; 32 symbols in order.
- Backpressure: count=2, out_ready random at 30% -> same 16-symbol sequence as with ready=1; out_data stable whenever valid and not ready.
- Start rules: start with count=0 -> busy stays 0, no output. start pulsed mid-line -> ignored, line completes unchanged.
- Reset mid-line: assert reset after 5 symbols -> all outputs 0 immediately. After release and a new start (base=9, count=1), word 9 is emitted cleanly.
